mod_inv_seq: RTL and testbench

MOD_INV_SEQ -- requirements
Module: mod_inv_seq

---
 rtl/mod_inv_seq.sv | 174 +++++++++++++++++
 tb/tb_mod_inv_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_inv_seq.sv
// rtl/mod_inv_seq.sv - Kaliski almost-Montgomery inverse, one step per cycle.
// Defining MOD_INV_CORRECT_EN adds the CORR phase that removes the 2^k factor.
module mod_inv_seq #(
  parameter int W   = 256,
  parameter int PAD = 2,
  parameter int KW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  p,
  output logic          ready,
  output logic          done,
  output logic [W-1:0]  value,
  output logic [KW-1:0] power,
  output logic          err
);

  localparam int IW = W + PAD;

`ifdef MOD_INV_CORRECT_EN
  typedef enum logic [1:0] {S_IDLE, S_LOOP, S_FIX, S_CORR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOOP, S_FIX} state_t;
`endif

  state_t        state_q, state_d;
  logic [W-1:0]  p_q, p_d;
  logic [IW-1:0] u_q, u_d, v_q, v_d, r_q, r_d, s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic          ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic [W-1:0]  value_q, value_d;
  logic [KW-1:0] power_q, power_d;
  logic [IW-1:0] pe, r_fix;
`ifdef MOD_INV_CORRECT_EN
  logic [KW-1:0] c_q, c_d;
  logic [IW-1:0] r_half;
`endif

  assign pe    = {{PAD{1'b0}}, p_q};
  assign r_fix = (r_q >= pe) ? (r_q - pe) : r_q;
`ifdef MOD_INV_CORRECT_EN
  // Halving modulo p: add p first when r is odd so the shift stays exact.
  assign r_half = r_q[0] ? ((r_q + pe) >> 1) : (r_q >> 1);
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    u_d     = u_q;
    v_d     = v_q;
    r_d     = r_q;
    s_d     = s_q;
    k_d     = k_q;
    done_d  = 1'b0;
    err_d   = err_q;
    value_d = value_q;
    power_d = power_q;
`ifdef MOD_INV_CORRECT_EN
    c_d     = c_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((a == '0) || (a >= p)) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            value_d = '0;
            power_d = '0;
          end else begin
            p_d     = p;
            u_d     = {{PAD{1'b0}}, p};
            v_d     = {{PAD{1'b0}}, a};
            r_d     = '0;
            s_d     = IW'(1);
            k_d     = '0;
            state_d = S_LOOP;
          end
        end
      end
      S_LOOP: begin
        k_d = k_q + KW'(1);
        if (!u_q[0]) begin
          u_d = u_q >> 1;
          s_d = s_q << 1;
        end else if (!v_q[0]) begin
          v_d = v_q >> 1;
          r_d = r_q << 1;
        end else if (u_q > v_q) begin
          u_d = (u_q - v_q) >> 1;
          r_d = r_q + s_q;
          s_d = s_q << 1;
        end else begin
          v_d = (v_q - u_q) >> 1;
          s_d = s_q + r_q;
          r_d = r_q << 1;
        end
        if (v_d == '0) state_d = S_FIX;
      end
      S_FIX: begin
`ifdef MOD_INV_CORRECT_EN
        r_d     = pe - r_fix;
        c_d     = k_q;
        state_d = S_CORR;
`else
        value_d = W'(pe - r_fix);
        power_d = k_q;
        err_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
`endif
      end
`ifdef MOD_INV_CORRECT_EN
      S_CORR: begin
        r_d = r_half;
        c_d = c_q - KW'(1);
        if (c_q == KW'(1)) begin
          value_d = W'(r_half);
          power_d = k_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      value_q <= '0;
      power_q <= '0;
`ifdef MOD_INV_CORRECT_EN
      c_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      u_q     <= u_d;
      v_q     <= v_d;
      r_q     <= r_d;
      s_q     <= s_d;
      k_q     <= k_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      value_q <= value_d;
      power_q <= power_d;
`ifdef MOD_INV_CORRECT_EN
      c_q     <= c_d;
`endif
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign err   = err_q;
  assign value = value_q;
  assign power = power_q;

endmodule

// File: tb/tb_mod_inv_seq.sv
// tb/tb_mod_inv_seq.sv - self-checking bench for mod_inv_seq against an arithmetic model.
module tb_mod_inv_seq;
  localparam int W  = 256;
  localparam int KW = 10;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  a, p;
  logic          ready, done, err;
  logic [W-1:0]  value;
  logic [KW-1:0] power;

  mod_inv_seq #(.W(W), .PAD(2), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .p(p),
    .ready(ready), .done(done), .value(value), .power(power), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           t0;
    int           tdone;
    logic [W-1:0] val;
    int           pw;
    logic         er;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_val = '0;
  int           last_pw = 0;

`ifdef MOD_INV_CORRECT_EN
  localparam int V37 = 5, L37 = 10, V17 = 1, L17 = 8;
`else
  localparam int V37 = 3, L37 = 6, V17 = 1, L17 = 5;
`endif

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] x;
    for (int j = 0; j < W / 32; j++) x[32*j +: 32] = $urandom;
    return x;
  endfunction

  // Number of Kaliski steps until v reaches zero.
  function automatic int model_k(input logic [W-1:0] ma, input logic [W-1:0] mp);
    logic [W-1:0] u, v;
    int k;
    u = mp; v = ma; k = 0;
    while (v != 0 && k < 4000) begin
      if (!u[0]) u = u >> 1;
      else if (!v[0]) v = v >> 1;
      else if (u > v) u = (u - v) >> 1;
      else v = (v - u) >> 1;
      k++;
    end
    return k;
  endfunction

  function automatic logic [W-1:0] model_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Extended Euclid with the Bezout coefficient kept reduced mod p.
  function automatic logic [W-1:0] model_inv(input logic [W-1:0] ma, input logic [W-1:0] mp);
    logic [W-1:0]   r0, r1, t0, t1, qq, tmp;
    logic [2*W-1:0] m, q2, t2, p2;
    r0 = mp; r1 = ma; t0 = '0; t1 = 1;
    while (r1 != 0) begin
      qq  = r0 / r1;
      tmp = r0 - qq * r1;
      r0  = r1; r1 = tmp;
      q2 = qq; t2 = t1; p2 = mp;
      m   = (q2 * t2) % p2;
      tmp = (t0 >= m[W-1:0]) ? (t0 - m[W-1:0]) : (t0 + (mp - m[W-1:0]));
      t0  = t1; t1 = tmp;
    end
    return t0;
  endfunction

  function automatic logic [W-1:0] mulpow2(input logic [W-1:0] x, input int k, input logic [W-1:0] mp);
    for (int i = 0; i < k; i++) begin
      x = x << 1;
      if (x >= mp) x = x - mp;
    end
    return x;
  endfunction

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] mp);
    logic [2*W-1:0] x2, y2, p2, r2;
    x2 = x; y2 = y; p2 = mp;
    r2 = (x2 * y2) % p2;
    return r2[W-1:0];
  endfunction

  always @(negedge clk) begin
    logic exp_ready;
    if (!rst) begin
      exp_ready = 1'b1;
      if (q.size() > 0) exp_ready = (cyc == q[0].t0) || (cyc == q[0].tdone);
      chk("ready", {{(W-1){1'b0}}, ready}, {{(W-1){1'b0}}, exp_ready});
      if (q.size() > 0 && cyc == q[0].tdone) begin
        chk("done_pulse", {{(W-1){1'b0}}, done}, 1);
        chk("value", value, q[0].val);
        chk("power", power, q[0].pw);
        chk("err", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, q[0].er});
        last_val = q[0].val;
        last_pw  = q[0].pw;
        void'(q.pop_front());
      end else begin
        chk("no_done", {{(W-1){1'b0}}, done}, 0);
        chk("value_held", value, last_val);
        chk("power_held", power, last_pw);
      end
    end
  end

  // Called right after a rising edge; returns right after the edge that raises done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tp, input logic [W-1:0] ev,
                        input int ek, input logic eerr, input int lat, input bit hold);
    exp_t e;
    start = 1'b1; a = ta; p = tp;
    e.t0 = cyc; e.tdone = cyc + lat; e.val = ev; e.pw = ek; e.er = eerr;
    q.push_back(e);
    while (cyc < e.tdone) begin
      @(posedge clk); #1;
      start = hold && (cyc < e.tdone);
      if (hold) begin
        a = rand_w();
        p = rand_w();
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rp, inv, ev, one;
    int k, nb, t0;
    exp_t e;
    rst = 1'b1; start = 1'b0; a = '0; p = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {{(W-1){1'b0}}, ready}, 1);
    chk("rst_done", {{(W-1){1'b0}}, done}, 0);
    chk("rst_err", {{(W-1){1'b0}}, err}, 0);
    chk("rst_value", value, 0);
    chk("rst_power", power, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    chk("model_k_3_7", model_k(3, 7), 4);
    chk("model_k_1_7", model_k(1, 7), 3);
    chk("model_inv_3_7", model_inv(3, 7), 5);
    chk("model_amm_3_7", mulpow2(5, 4, 7), 3);

    run_op(3, 7, V37, 4, 1'b0, L37, 1'b0);
    run_op(0, 7, 0, 0, 1'b1, 1, 1'b0);
    run_op(9, 7, 0, 0, 1'b1, 1, 1'b0);
    run_op(7, 7, 0, 0, 1'b1, 1, 1'b0);
    run_op(1, 7, V17, 3, 1'b0, L17, 1'b1);

    // Abort a=3/p=7 with reset two cycles after acceptance.
    start = 1'b1; a = 3; p = 7; t0 = cyc;
    e.t0 = t0; e.tdone = t0 + L37; e.val = V37; e.pw = 4; e.er = 1'b0;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    last_val = '0;
    last_pw  = 0;
    #1;
    chk("abort_ready", {{(W-1){1'b0}}, ready}, 1);
    chk("abort_done", {{(W-1){1'b0}}, done}, 0);
    chk("abort_value", value, 0);
    chk("abort_power", power, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    run_op(3, 7, V37, 4, 1'b0, L37, 1'b0);

    for (int i = 0; i < 30; i++) begin
      nb = $urandom_range(255, 8);
      rp = rand_w();
      rp = rp & ((256'd1 << nb) - 1);
      rp[nb-1] = 1'b1;
      rp[0] = 1'b1;
      do begin
        ra = rand_w() % rp;
      end while (ra == 0 || model_gcd(rp, ra) != 1);
      k   = model_k(ra, rp);
      inv = model_inv(ra, rp);
`ifdef MOD_INV_CORRECT_EN
      ev  = inv;
      run_op(ra, rp, ev, k, 1'b0, 2 * k + 2, (i % 2) == 1);
      one = 1;
      chk("rand_a_times_value", mulmod(ra, value, rp), one);
`else
      ev  = mulpow2(inv, k, rp);
      run_op(ra, rp, ev, k, 1'b0, k + 2, (i % 2) == 1);
      one = 1;
      chk("rand_a_times_value", mulmod(ra, value, rp), mulpow2(one, k, rp));
`endif
      chk("rand_power_range", {{(W-1){1'b0}}, (int'(power) >= nb) && (int'(power) <= 2 * nb)}, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
